// File: rtl/cu_mc.sv
// Multi-cycle CPU control unit: state sequencing, datapath control decode and
// optional saturating perf counters (enabled by defining CU_MC_PERF_CNT_EN).
module cu_mc #(
   parameter int OPW  = 4,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            init,
   input  logic [OPW-1:0]  OPCcode,
   input  logic            memReady,
   output logic            wDataSrc,
   output logic            AluSrcB,
   output logic            memWrite,
   output logic            memRead,
   output logic            PCwrite,
   output logic            PCWriteCond,
   output logic            IRwrite,
   output logic            IorD,
   output logic            regWrite,
   output logic            move,
   output logic [1:0]      PCsrc,
   output logic [1:0]      AluSrcA,
   output logic [2:0]      ALU_OP,
   output logic            instrDone,
   output logic            halted,
   output logic            illegal,
   output logic [CNTW-1:0] instrCount,
   output logic [CNTW-1:0] stallCount
);

   // state    | meaning
   // IF / ID  | fetch (waits on memReady) / decode
   // LOAD1/2  | load address phase (waits) / register write-back
   // STORE    | store (waits); JUMP, BRANCHZ | PC update
   // RTL1/2   | register move compute / write
   // EXI / WB | immediate ALU op / write-back with held ALU_OP
   // HALT     | halted, absorbing;  TRAP | illegal opcode, absorbing
   typedef enum logic [3:0] {
      ST_IF, ST_ID, ST_LOAD1, ST_LOAD2, ST_STORE, ST_JUMP, ST_BRANCHZ,
      ST_RTL1, ST_RTL2, ST_EXI, ST_WB, ST_HALT, ST_TRAP
   } state_t;

   state_t     state_q, state_d, decode_st;
   logic [2:0] alu_op_q, alu_op_d, exi_alu;
   logic       upper_nz;

   generate
      if (OPW > 4) begin : g_upper
         assign upper_nz = |OPCcode[OPW-1:4];
      end else begin : g_no_upper
         assign upper_nz = 1'b0;
      end
   endgenerate

   always_comb begin
      decode_st = ST_TRAP;
      if (!upper_nz) begin
         case (OPCcode[3:0])
            4'b0000: decode_st = ST_LOAD1;
            4'b0001: decode_st = ST_STORE;
            4'b0010: decode_st = ST_JUMP;
            4'b0011: decode_st = ST_HALT;
            4'b0100: decode_st = ST_BRANCHZ;
            4'b1000: decode_st = ST_RTL1;
            4'b1100, 4'b1101, 4'b1110, 4'b1111: decode_st = ST_EXI;
            default: decode_st = ST_TRAP;
         endcase
      end
      case (OPCcode[1:0])
         2'b00:   exi_alu = 3'b001;
         2'b01:   exi_alu = 3'b010;
         2'b10:   exi_alu = 3'b011;
         default: exi_alu = 3'b100;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      alu_op_d = (state_q == ST_EXI) ? exi_alu : alu_op_q;
      case (state_q)
         ST_IF:      if (memReady) state_d = ST_ID;
         ST_ID:      state_d = decode_st;
         ST_LOAD1:   if (memReady) state_d = ST_LOAD2;
         ST_STORE:   if (memReady) state_d = ST_IF;
         ST_RTL1:    state_d = ST_RTL2;
         ST_EXI:     state_d = ST_WB;
         ST_LOAD2, ST_JUMP, ST_BRANCHZ, ST_RTL2, ST_WB: state_d = ST_IF;
         ST_HALT:    state_d = ST_HALT;
         ST_TRAP:    state_d = ST_TRAP;
         default:    state_d = ST_IF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state_q  <= ST_IF;
         alu_op_q <= 3'b001;
      end else begin
         state_q  <= state_d;
         alu_op_q <= alu_op_d;
      end
   end

   always_comb begin
      wDataSrc    = 1'b0;
      AluSrcB     = 1'b0;
      memWrite    = 1'b0;
      memRead     = 1'b0;
      PCwrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRwrite     = 1'b0;
      IorD        = 1'b0;
      regWrite    = 1'b0;
      move        = 1'b0;
      PCsrc       = 2'b00;
      AluSrcA     = 2'b00;
      ALU_OP      = 3'b001;
      instrDone   = 1'b0;
      halted      = 1'b0;
      illegal     = 1'b0;
      case (state_q)
         ST_IF: begin
            memRead = 1'b1;
            AluSrcA = 2'b01;
            AluSrcB = 1'b1;
            IRwrite = memReady;
            PCwrite = memReady;
         end
         ST_ID:      instrDone = (decode_st == ST_HALT);
         ST_LOAD1: begin
            memRead = 1'b1;
            IorD    = 1'b1;
         end
         ST_LOAD2: begin
            regWrite  = 1'b1;
            instrDone = 1'b1;
         end
         ST_STORE: begin
            memWrite  = 1'b1;
            IorD      = 1'b1;
            instrDone = memReady;
         end
         ST_JUMP: begin
            PCsrc     = 2'b10;
            PCwrite   = 1'b1;
            instrDone = 1'b1;
         end
         ST_BRANCHZ: begin
            AluSrcA     = 2'b10;
            PCsrc       = 2'b01;
            PCWriteCond = 1'b1;
            ALU_OP      = 3'b010;
            instrDone   = 1'b1;
         end
         ST_RTL1: begin
            AluSrcA = 2'b10;
            ALU_OP  = 3'b000;
         end
         ST_RTL2: begin
            move      = 1'b1;
            regWrite  = 1'b1;
            wDataSrc  = 1'b1;
            ALU_OP    = 3'b000;
            instrDone = 1'b1;
         end
         ST_EXI:     ALU_OP = exi_alu;
         ST_WB: begin
            regWrite  = 1'b1;
            wDataSrc  = 1'b1;
            ALU_OP    = alu_op_q;
            instrDone = 1'b1;
         end
         ST_HALT: begin
            ALU_OP = 3'b000;
            halted = 1'b1;
         end
         ST_TRAP: begin
            ALU_OP  = 3'b000;
            illegal = 1'b1;
         end
         default: ALU_OP = 3'b001;
      endcase
      // reset overrides everything, including the ALU_OP default
      if (init) begin
         wDataSrc    = 1'b0;
         AluSrcB     = 1'b0;
         memWrite    = 1'b0;
         memRead     = 1'b0;
         PCwrite     = 1'b0;
         PCWriteCond = 1'b0;
         IRwrite     = 1'b0;
         IorD        = 1'b0;
         regWrite    = 1'b0;
         move        = 1'b0;
         PCsrc       = 2'b00;
         AluSrcA     = 2'b00;
         ALU_OP      = 3'b000;
         instrDone   = 1'b0;
         halted      = 1'b0;
         illegal     = 1'b0;
      end
   end

`ifdef CU_MC_PERF_CNT_EN
   logic [CNTW-1:0] instr_cnt_q, stall_cnt_q;
   logic            stall;

   assign stall = ((state_q == ST_IF) || (state_q == ST_LOAD1) ||
                   (state_q == ST_STORE)) && !memReady;

   always_ff @(posedge clk) begin
      if (init) begin
         instr_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (instrDone && (instr_cnt_q != '1)) instr_cnt_q <= instr_cnt_q + CNTW'(1);
         if (stall && (stall_cnt_q != '1))     stall_cnt_q <= stall_cnt_q + CNTW'(1);
      end
   end

   assign instrCount = instr_cnt_q;
   assign stallCount = stall_cnt_q;
`else
   assign instrCount = '0;
   assign stallCount = '0;
`endif

endmodule
